gcd_arbiter: RTL and testbench

//   Shares one GCD engine among N_REQ requesters. Accepts one request at a time,

---
 rtl/gcd_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter
//   Shares a single external GCD engine among N_REQ requesters. One request is
//   accepted at a time through a round-robin grant. The arbiter drives the
//   engine's operands and load pulse, waits for the engine's valid flag and
//   returns the result tagged with the requester id. A watchdog aborts a run
//   that takes MAX_CYCLES cycles in RUN and reports a timeout with result 0.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake, req_ready is one-hot in IDLE
//   req_a/req_b           packed signed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_result     served requester and gcd(|a|,|b|) (0 on timeout)
//   rsp_timeout           run aborted by the watchdog
//   gcd_a/gcd_b/gcd_load  registered operands and one-cycle load pulse to engine
//   gcd_is_valid/gcd_result  engine status and result
//   busy                  high in every state except IDLE
module gcd_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 63,
    parameter int MAX_CYCLES = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_W-1:0]    req_a,
    input  logic [N_REQ*DATA_W-1:0]    req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]          rsp_result,
    output logic                       rsp_timeout,
    output logic [DATA_W-1:0]          gcd_a,
    output logic [DATA_W-1:0]          gcd_b,
    output logic                       gcd_load,
    input  logic                       gcd_is_valid,
    input  logic [DATA_W-1:0]          gcd_result,
    output logic                       busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic [DATA_W-1:0]   gcd_a_q, gcd_a_d;
    logic [DATA_W-1:0]   gcd_b_q, gcd_b_d;
    logic                gcd_load_q, gcd_load_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    // Request vector rotated so that position 0 is the requester at rr_ptr.
    logic [ID_W-1:0]     rot_idx [N_REQ];
    logic [N_REQ-1:0]    rot_valid;
    logic [DATA_W-1:0]   a_slice [N_REQ];
    logic [DATA_W-1:0]   b_slice [N_REQ];
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [ID_W:0] sum;
            assign sum          = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
            assign rot_idx[gi]  = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                            : ID_W'(sum);
            assign rot_valid[gi] = req_valid[rot_idx[gi]];
            assign a_slice[gi]   = req_a[gi*DATA_W +: DATA_W];
            assign b_slice[gi]   = req_b[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan downward so the lowest rotated position (closest to rr_ptr) wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = rot_idx[k];
            end
        end
    end

    // Accept is combinational and only offered while IDLE; suppressed during
    // reset so a request is never acknowledged on a cycle that gets discarded.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        counter_d     = counter_q;
        gcd_a_d       = gcd_a_q;
        gcd_b_d       = gcd_b_q;
        gcd_load_d    = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    gcd_a_d    = a_slice[grant_idx];
                    gcd_b_d    = b_slice[grant_idx];
                    id_d       = grant_idx;
                    gcd_load_d = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // The engine's valid flag can still reflect the previous job here.
                counter_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (gcd_is_valid) begin
                    rsp_result_d  = gcd_result;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = id_q;
                    state_d       = S_RESP;
                end else if (counter_q == CNT_W'(MAX_CYCLES - 1)) begin
                    rsp_result_d  = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = id_q;
                    state_d       = S_RESP;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            counter_q     <= '0;
            gcd_a_q       <= '0;
            gcd_b_q       <= '0;
            gcd_load_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            counter_q     <= counter_d;
            gcd_a_q       <= gcd_a_d;
            gcd_b_q       <= gcd_b_d;
            gcd_load_q    <= gcd_load_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign gcd_a       = gcd_a_q;
    assign gcd_b       = gcd_b_q;
    assign gcd_load    = gcd_load_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: a behavioural engine with programmable latency, a
// round-robin pick model and a Euclid reference for the expected result.
module tb_gcd_arbiter;

    localparam int N   = 4;
    localparam int W   = 63;
    localparam int MAX = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_result;
    logic             rsp_timeout;
    logic [W-1:0]     gcd_a, gcd_b;
    logic             gcd_load;
    logic             gcd_is_valid = 1'b0;
    logic [W-1:0]     gcd_result = '0;
    logic             busy;

    logic [W-1:0]     a_op [N];
    logic [W-1:0]     b_op [N];

    int vectors    = 0;
    int miscompares = 0;
    int rr_model   = 0;
    int eng_delay  = 0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_a[gi*W +: W] = a_op[gi];
            assign req_b[gi*W +: W] = b_op[gi];
        end
    endgenerate

    gcd_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_CYCLES(MAX)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_timeout  (rsp_timeout),
        .gcd_a        (gcd_a),
        .gcd_b        (gcd_b),
        .gcd_load     (gcd_load),
        .gcd_is_valid (gcd_is_valid),
        .gcd_result   (gcd_result),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a[W-1] ? -a : a;
        y = b[W-1] ? -b : b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m, input int rr);
        for (int k = 0; k < N; k++) begin
            if (m[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] gen_op();
        logic [W-1:0] v;
        if ($urandom_range(0, 7) == 0) return '0;
        v = W'($urandom_range(1, 300)) * W'($urandom_range(0, 20000));
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // Engine stand-in: the valid flag keeps its old value through the cycle
    // after the load, then reports the new result eng_delay cycles later.
    logic         eng_busy = 1'b0;
    int           eng_cnt  = 0;
    logic [W-1:0] eng_a = '0, eng_b = '0;
    always @(posedge clock) begin
        if (gcd_load) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_delay;
            eng_a    <= gcd_a;
            eng_b    <= gcd_b;
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                gcd_is_valid <= 1'b1;
                gcd_result   <= ref_gcd(eng_a, eng_b);
                eng_busy     <= 1'b0;
            end else begin
                gcd_is_valid <= 1'b0;
                eng_cnt      <= eng_cnt - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negative edge; returns just after the negative edge
    // of the cycle following the response handshake.
    task automatic do_txn(input logic [N-1:0] vmask, input int delay, input int hold,
                          output int got_id, output logic [W-1:0] got_res, output logic got_to);
        int           exp_idx, lat, loads;
        logic         exp_to;
        logic [W-1:0] exp_res;
        logic [1:0]   h_id;
        logic [W-1:0] h_res;
        logic         h_to;
        req_valid = vmask;
        eng_delay = delay;
        rsp_ready = 1'b0;
        #1;
        exp_idx = rr_pick(vmask, rr_model);
        exp_to  = (delay >= MAX);
        exp_res = exp_to ? '0 : ref_gcd(a_op[exp_idx], b_op[exp_idx]);
        check_eq("grant", 64'(req_ready), 64'(1 << exp_idx));
        check_eq("idle_busy", 64'(busy), 64'd0);
        lat   = 0;
        loads = 0;
        forever begin
            @(negedge clock);
            lat++;
            if (gcd_load) loads++;
            if (lat == 1) check_eq("load_pulse", 64'(gcd_load), 64'd1);
            if (rsp_valid) break;
            if (req_ready != '0) check_eq("ready_while_busy", 64'(req_ready), 64'd0);
            if (lat > 100) begin
                check_eq("rsp_wait_bound", 64'(rsp_valid), 64'd1);
                break;
            end
        end
        check_eq("latency", 64'(lat), 64'(exp_to ? MAX + 3 : delay + 4));
        check_eq("rsp_id", 64'(rsp_id), 64'(exp_idx));
        check_eq("rsp_result", 64'(rsp_result), 64'(exp_res));
        check_eq("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        check_eq("gcd_a", 64'(gcd_a), 64'(a_op[exp_idx]));
        check_eq("gcd_b", 64'(gcd_b), 64'(b_op[exp_idx]));
        check_eq("load_count", 64'(loads), 64'd1);
        got_id  = int'(rsp_id);
        got_res = rsp_result;
        got_to  = rsp_timeout;
        h_id = rsp_id; h_res = rsp_result; h_to = rsp_timeout;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check_eq("hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("hold_fields", {rsp_id, rsp_timeout, rsp_result}, {h_id, h_to, h_res});
            check_eq("hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("hs_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        rsp_ready = 1'b0;
        check_eq("post_hs_valid", 64'(rsp_valid), 64'd0);
        check_eq("post_hs_busy", 64'(busy), 64'd0);
        rr_model = (exp_idx + 1) % N;
        $display("txn id=%0d a=%0d b=%0d delay=%0d hold=%0d lat=%0d result=%0d timeout=%0b",
                 got_id, $signed(a_op[exp_idx]), $signed(b_op[exp_idx]), delay, hold, lat,
                 got_res, got_to);
    endtask

    initial begin
        int           id;
        logic [W-1:0] res;
        logic         to;
        logic         seen;
        for (int i = 0; i < N; i++) begin
            a_op[i] = W'(i + 3);
            b_op[i] = W'(i + 5);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("reset_ctrl", {60'd0, rsp_valid, rsp_timeout, gcd_load, busy}, 64'd0);
        check_eq("reset_ready", 64'(req_ready), 64'd0);
        check_eq("reset_data", 64'(rsp_result) | 64'(gcd_a) | 64'(gcd_b) | 64'(rsp_id), 64'd0);

        // Basic job
        a_op[0] = 63'd48; b_op[0] = 63'd18;
        do_txn(4'b0001, 2, 0, id, res, to);
        check_eq("t1_result", 64'(res), 64'd6);

        // Everyone requesting: strict rotation
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) begin a_op[i] = gen_op(); b_op[i] = gen_op(); end
            do_txn(4'b1111, $urandom_range(0, 4), 0, id, res, to);
        end

        // Minimum latency with b = 0 and a negative operand
        a_op[2] = '0 - 63'd21; b_op[2] = '0;
        do_txn(4'b0100, 0, 0, id, res, to);
        check_eq("t3_result", 64'(res), 64'd21);

        // Consumer stalls while another requester waits
        do_txn(4'b0011, 1, 5, id, res, to);

        // Watchdog boundary and timeout
        a_op[1] = 63'd77; b_op[1] = 63'd21;
        do_txn(4'b0010, MAX - 1, 0, id, res, to);
        check_eq("edge_no_timeout", 64'(to), 64'd0);
        a_op[1] = 63'd1000; b_op[1] = 63'd1;
        do_txn(4'b0010, 40, 1, id, res, to);
        check_eq("t5_timeout", 64'(to), 64'd1);
        a_op[1] = 63'd12; b_op[1] = 63'd8;
        do_txn(4'b0010, 3, 0, id, res, to);
        check_eq("t5_after", 64'(res), 64'd4);

        // Reset during RUN (rr_model is 2 here)
        req_valid = 4'b0100;
        eng_delay = 50;
        #1;
        check_eq("abort_grant", 64'(req_ready), 64'b0100);
        repeat (5) @(negedge clock);
        check_eq("abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("abort_ctrl", {60'd0, rsp_valid, rsp_timeout, gcd_load, busy}, 64'd0);
        check_eq("abort_data", 64'(rsp_result) | 64'(gcd_a) | 64'(gcd_b) | 64'(req_ready), 64'd0);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (rsp_valid || busy) seen = 1'b1;
        end
        check_eq("abort_quiet", 64'(seen), 64'd0);
        rr_model = 0;
        a_op[0] = 63'd35; b_op[0] = 63'd14;
        a_op[3] = 63'd99; b_op[3] = 63'd33;
        do_txn(4'b1001, 1, 0, id, res, to);
        check_eq("t6_id", 64'(id), 64'd0);
        check_eq("t6_result", 64'(res), 64'd7);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++) begin a_op[i] = gen_op(); b_op[i] = gen_op(); end
            m = N'($urandom_range(1, 15));
            do_txn(m, $urandom_range(0, 10), $urandom_range(0, 3), id, res, to);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
